ascii_case_stream: RTL and testbench
====================================

ASCII_CASE_STREAM -- requirements
Module: ascii_case_stream

Interface
REQ-001 Parameter LANES, default 4, number of 8-bit characters per beat (1..16).
REQ-002 Parameter CNT_W, default 16, width of the converted-character counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mode  input  2  case mode: 0 PASS, 1 UPPER, 2 LOWER, 3 TOGGLE; sampled on first beat of a packet.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 in_data  input  8*LANES  characters; lane k at bits [8k+7:8k].
REQ-009 in_last  input  1  final beat of packet.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  8*LANES  converted characters, same lane order.
REQ-013 out_last  output  1  copy of in_last for that beat.
REQ-014 cnt_clr  input  1  synchronous clear of conv_count.
REQ-015 conv_count  output  CNT_W  saturating count of characters actually changed.

Function
REQ-016 Beat transfer on input SHALL occur when in_valid and in_ready are both 1 at a rising edge; likewise out_valid/out_ready on output.
REQ-017 Per byte: UPPER maps 0x61-0x7A to value-0x20; LOWER maps 0x41-0x5A to value+0x20; TOGGLE applies both; PASS changes nothing; all other bytes (incl. 0x80-0xFF, 0x5B-0x60, 0x7B-0x7F) SHALL pass unchanged.
REQ-018 Mode SHALL be captured on the first accepted beat after reset or after an accepted beat with in_last=1, and held for all beats of that packet; mode changes mid-packet SHALL be ignored.
REQ-019 The capture beat itself SHALL use the live mode value.
REQ-020 Datapath SHALL be a 2-entry output buffer (skid); in_ready SHALL be a registered signal equal to 1 when buffer occupancy < 2.
REQ-021 Latency: a beat accepted at edge N SHALL be presented on out_* starting after edge N (visible in the cycle following acceptance) when the buffer was empty.
REQ-022 Throughput SHALL be one beat per cycle when out_ready is held 1; order SHALL be preserved; no beat dropped or duplicated.
REQ-023 Simultaneous accept and emit with occupancy 2: not possible (in_ready=0); with occupancy 1: occupancy stays 1.
REQ-024 out_data/out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 conv_count SHALL increase by the number of bytes changed in each accepted input beat, saturating at 2^CNT_W-1.
REQ-026 If cnt_clr and an accepted beat coincide, conv_count SHALL become that beat's changed-byte count; cnt_clr alone SHALL set it to 0.

Reset
REQ-027 On rst: out_valid=0, in_ready=0 while rst asserted then 1 on the first edge after release, occupancy=0, conv_count=0, out_data=0, out_last=0, packet state = "expect first beat".
REQ-028 Reset mid-packet SHALL discard buffered beats; the next accepted beat starts a new packet.

Structure
REQ-029 Shared package ascii_case_pkg SHALL hold mode constants (MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE) and case-offset constant 0x20.
REQ-030 Sub-module ascii_case_lane SHALL be the combinational per-byte converter (inputs byte, mode; outputs byte, changed flag), instantiated LANES times.

Verification
REQ-031 LANES=4, mode=UPPER, single-beat packet "abZ{" (0x61 0x62 0x5A 0x7B), out_ready=1 -> out "ABZ{" next cycle, out_last=1, conv_count=2.
REQ-032 mode=TOGGLE on beat 1 of 3-beat packet, mode switched to PASS on beat 2 -> all 3 beats toggled; next packet uses PASS.
REQ-033 out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats accepted, in_ready=0 thereafter, out_data stable; release -> beats in order, no loss.
REQ-034 CNT_W=4, 5 beats each with 4 changed bytes -> conv_count saturates at 15; cnt_clr with concurrent beat of 3 changes -> 3.
REQ-035 Bytes 0x80, 0xE1, 0x40, 0x60 in LOWER and UPPER modes -> unchanged, count unchanged.
REQ-036 rst asserted with 2 beats buffered mid-packet -> out_valid=0 asynchronously, conv_count=0; next beat's mode captured fresh.

Source files
------------

// File: rtl/ascii_case_pkg.sv
// ascii_case_pkg: shared definitions for the ASCII case-conversion stream.
//   mode_e   - case mode encoding as seen on the mode input
//   CASE_OFS - distance between an upper- and a lower-case ASCII letter
package ascii_case_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  localparam logic [7:0] CASE_OFS = 8'h20;

endpackage

// File: rtl/ascii_case_lane.sv
// ascii_case_lane: combinational single-byte case converter.
//   ch_i   - input character
//   mode_i - case mode for this beat
//   ch_o   - converted character (non-letters pass through untouched)
//   chg_o  - 1 when ch_o differs from ch_i
module ascii_case_lane
  import ascii_case_pkg::*;
(
  input  logic [7:0] ch_i,
  input  mode_e      mode_i,
  output logic [7:0] ch_o,
  output logic       chg_o
);

  logic is_lo, is_up, do_up, do_lo;

  assign is_lo = (ch_i >= 8'h61) && (ch_i <= 8'h7A);
  assign is_up = (ch_i >= 8'h41) && (ch_i <= 8'h5A);

  // TOGGLE enables both directions; a byte can only be one case, so at most one fires.
  assign do_up = is_lo && ((mode_i == MODE_UPPER) || (mode_i == MODE_TOGGLE));
  assign do_lo = is_up && ((mode_i == MODE_LOWER) || (mode_i == MODE_TOGGLE));

  assign ch_o  = do_up ? (ch_i - CASE_OFS) :
                 do_lo ? (ch_i + CASE_OFS) : ch_i;
  assign chg_o = do_up | do_lo;

endmodule

// File: rtl/ascii_case_stream.sv
// ascii_case_stream: valid/ready stream that changes ASCII letter case per
// packet, with a 2-entry output buffer and a saturating changed-byte counter.
//   clk, rst             - clock, asynchronous active-high reset
//   mode                 - case mode, captured on the first beat of a packet
//   in_valid/in_ready    - input handshake (in_ready registered)
//   in_data/in_last      - input characters (lane k at [8k+7:8k]) and packet end
//   out_valid/out_ready  - output handshake
//   out_data/out_last    - converted characters and packet end
//   cnt_clr              - synchronous clear of conv_count
//   conv_count           - saturating count of bytes actually changed
module ascii_case_stream
  import ascii_case_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     conv_count
);

  localparam int NW = $clog2(LANES + 1);
  // Sum width wide enough for count + per-beat changes without wrapping.
  localparam int SW = ((CNT_W > NW) ? CNT_W : NW) + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  // Packet state: first_q = 1 means the next accepted beat opens a packet.
  mode_e mode_q, mode_d;
  logic  first_q, first_d;
  mode_e mode_eff;

  logic [LANES-1:0][7:0] cnv;
  logic [LANES-1:0]      chg;
  logic [NW-1:0]         nchg;

  logic [LANES-1:0][7:0] d0_q, d0_d, d1_q, d1_d;
  logic                  l0_q, l0_d, l1_q, l1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  in_ready_q, in_ready_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]         base, sum;

  logic push, pop;

  // The opening beat converts with the live mode; later beats use the held one.
  assign mode_eff = first_q ? mode_e'(mode) : mode_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ascii_case_lane u_lane (
      .ch_i   (in_data[8*k +: 8]),
      .mode_i (mode_eff),
      .ch_o   (cnv[k]),
      .chg_o  (chg[k])
    );
  end

  always_comb begin
    nchg = '0;
    for (int k = 0; k < LANES; k++) nchg = nchg + NW'(chg[k]);
  end

  assign push = in_valid & in_ready_q;
  assign pop  = (occ_q != 2'd0) & out_ready;

  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    l0_d    = l0_q;
    l1_d    = l1_q;
    occ_d   = occ_q;
    mode_d  = mode_q;
    first_d = first_q;

    if (push) begin
      if (first_q) mode_d = mode_e'(mode);
      first_d = in_last;
    end

    // Slot 0 is the head presented on out_*; slot 1 only fills when head is stalled.
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          d0_d = cnv;
          l0_d = in_last;
        end else begin
          d1_d = cnv;
          l1_d = in_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) begin
          d0_d = d1_q;
          l0_d = l1_q;
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Push is only possible with occupancy below 2, so here occupancy is 1.
        d0_d = cnv;
        l0_d = in_last;
      end
      default: ;
    endcase

    in_ready_d = (occ_d < 2'd2);
  end

  // A clear coinciding with a beat restarts the count from that beat's changes.
  always_comb begin
    base  = cnt_clr ? '0 : SW'(cnt_q);
    sum   = base + (push ? SW'(nchg) : '0);
    cnt_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q       <= '0;
      d1_q       <= '0;
      l0_q       <= 1'b0;
      l1_q       <= 1'b0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= MODE_PASS;
      first_q    <= 1'b1;
    end else begin
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      l0_q       <= l0_d;
      l1_q       <= l1_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      first_q    <= first_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = d0_q;
  assign out_last   = l0_q;
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_ascii_case_stream.sv
module tb_ascii_case_stream;

  localparam int LANES = 4;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic                 out_last;
  logic                 cnt_clr;
  logic [CNT_W-1:0]     conv_count;

  int n_asrt = 0;
  int n_fail = 0;

  ascii_case_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .cnt_clr    (cnt_clr),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_count",     {28'd0, conv_count}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_last",  {31'd0, out_last}, 32'd0);
    rst = 1'b0;
    step();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // UPPER single-beat "abZ{"
    mode = 2'd1; in_valid = 1'b1; in_data = 32'h7B5A6261; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    chk("up_valid", {31'd0, out_valid}, 32'd1);
    chk("up_data",  out_data, 32'h7B5A4241);
    chk("up_last",  {31'd0, out_last}, 32'd1);
    chk("up_count", {28'd0, conv_count}, 32'd2);
    step();
    chk("up_drain", {31'd0, out_valid}, 32'd0);

    // Mode held across a 3-beat TOGGLE packet
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr_only", {28'd0, conv_count}, 32'd0);
    mode = 2'd3; in_valid = 1'b1; in_data = 32'h44634261; in_last = 1'b0;
    step();
    chk("tg_b1", out_data, 32'h64436241);
    chk("tg_b1_last", {31'd0, out_last}, 32'd0);
    mode = 2'd0; in_data = 32'h7A5A2131;
    step();
    chk("tg_b2", out_data, 32'h5A7A2131);
    mode = 2'd2; in_data = 32'h41414161; in_last = 1'b1;
    step();
    chk("tg_b3", out_data, 32'h61616141);
    chk("tg_b3_last", {31'd0, out_last}, 32'd1);
    chk("tg_count", {28'd0, conv_count}, 32'd10);
    mode = 2'd0;
    step();
    chk("pass_next", out_data, 32'h41414161);
    chk("pass_count", {28'd0, conv_count}, 32'd10);
    in_valid = 1'b0;
    step();

    // Backpressure: buffer fills with two beats, then drains in order
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    out_ready = 1'b0; mode = 2'd1; in_valid = 1'b1; in_data = 32'h64636261; in_last = 1'b0;
    step();
    chk("bp_rdy_occ1", {31'd0, in_ready}, 32'd1);
    in_data = 32'h68676665; in_last = 1'b1;
    step();
    mode = 2'd0; in_data = 32'h6C6B6A69; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_rdy_full", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_data", out_data, 32'h44434241);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("bp_count", {28'd0, conv_count}, 32'd8);
    out_ready = 1'b1;
    step();
    chk("bp_d2", out_data, 32'h48474645);
    chk("bp_d2_last", {31'd0, out_last}, 32'd1);
    chk("bp_rdy_back", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_d3", out_data, 32'h6C6B6A69);
    chk("bp_count2", {28'd0, conv_count}, 32'd8);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Saturation at 15 with CNT_W=4, then clear coinciding with a beat
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    mode = 2'd1; in_valid = 1'b1; in_data = 32'h64636261; in_last = 1'b1;
    step(); step(); step();
    chk("sat_12", {28'd0, conv_count}, 32'd12);
    step();
    chk("sat_15", {28'd0, conv_count}, 32'd15);
    step();
    chk("sat_hold", {28'd0, conv_count}, 32'd15);
    cnt_clr = 1'b1; in_data = 32'h44636261;
    step();
    cnt_clr = 1'b0;
    chk("clr_beat", {28'd0, conv_count}, 32'd3);
    chk("clr_beat_data", out_data, 32'h44434241);

    // Non-letter boundary bytes unchanged in LOWER and UPPER
    mode = 2'd2; in_data = 32'h6040E180;
    step();
    chk("nl_lower", out_data, 32'h6040E180);
    chk("nl_lower_cnt", {28'd0, conv_count}, 32'd3);
    mode = 2'd1; in_data = 32'h7B5B7F80;
    step();
    chk("nl_upper", out_data, 32'h7B5B7F80);
    chk("nl_upper_cnt", {28'd0, conv_count}, 32'd3);
    in_valid = 1'b0;
    step();

    // Reset mid-packet with two beats buffered
    out_ready = 1'b0; mode = 2'd3; in_valid = 1'b1; in_data = 32'h64636261; in_last = 1'b0;
    step(); step();
    in_valid = 1'b0;
    chk("pre_rst_cnt", {28'd0, conv_count}, 32'd11);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", {28'd0, conv_count}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    mode = 2'd1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h44634261; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fresh_mode", out_data, 32'h44434241);
    chk("fresh_count", {28'd0, conv_count}, 32'd2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
